// File: rtl/alu_seq_if.sv
// Valid/ready bus for alu_seq: operand/op request channel and result/status response channel.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [1:0]       flags;
  logic             dz;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, dz
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, dz
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes; MUL iterative unless FAST_MUL, DIV iterative.
// Define ALU_DIV_EN to build the restoring divider; otherwise DIVA returns 0 with dz set.
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int FAST_MUL = 0
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       op_r;
  // p_r: product accumulator / partial remainder; x_r: multiplicand / dividend-quotient; y_r: multiplier / divisor
  logic [WIDTH-1:0] p_r, x_r, y_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] result_r;
  logic [1:0]       flags_r;
  logic             dz_r;

  logic             accept_s, iter_s, last_s, fast_dz_s;
  logic [WIDTH-1:0] fast_res_s, iter_res_s, step_p_s, step_x_s, step_y_s;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_shift_s, diff_s;
`endif

  function automatic logic [1:0] flags_of(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], (r == '0)};
  endfunction

  assign accept_s      = bus.in_valid && bus.in_ready;
  assign last_s        = (state_r == ST_BUSY) && (cnt_r == CNT_W'(WIDTH - 1));
  assign bus.in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
  assign bus.dz        = dz_r;

  // Decode incoming op: single-cycle result or hand-off to the iterative engine
  always_comb begin
    fast_res_s = '0;
    fast_dz_s  = 1'b0;
    iter_s     = 1'b0;
    case (bus.op)
      OP_ADD: fast_res_s = bus.a + bus.b;
      OP_SUB: fast_res_s = bus.a - bus.b;
      OP_MUL: begin
        if (FAST_MUL != 0) begin
          fast_res_s = bus.a * bus.b;
        end else begin
          iter_s = 1'b1;
        end
      end
      OP_DIV: begin
`ifdef ALU_DIV_EN
        if (bus.b == '0) begin
          fast_res_s = '1;
          fast_dz_s  = 1'b1;
        end else begin
          iter_s = 1'b1;
        end
`else
        fast_res_s = '0;
        fast_dz_s  = 1'b1;
`endif
      end
      OP_AND:  fast_res_s = bus.a & bus.b;
      OP_OR:   fast_res_s = bus.a | bus.b;
      OP_XOR:  fast_res_s = bus.a ^ bus.b;
      OP_NOT:  fast_res_s = ~bus.a;
      default: fast_res_s = '0;
    endcase
  end

  // One shift-add or restoring-division step on the latched operands
  always_comb begin
    step_p_s = p_r;
    step_x_s = x_r;
    step_y_s = y_r;
`ifdef ALU_DIV_EN
    rem_shift_s = '0;
    diff_s      = '0;
`endif
    if (op_r == OP_MUL) begin
      if (y_r[0]) begin
        step_p_s = p_r + x_r;
      end else begin
        step_p_s = p_r;
      end
      step_x_s = x_r << 1'b1;
      step_y_s = y_r >> 1'b1;
    end else begin
`ifdef ALU_DIV_EN
      rem_shift_s = {p_r, x_r[WIDTH-1]};
      diff_s      = rem_shift_s - {1'b0, y_r};
      if (!diff_s[WIDTH]) begin
        step_p_s = diff_s[WIDTH-1:0];
        step_x_s = {x_r[WIDTH-2:0], 1'b1};
      end else begin
        step_p_s = rem_shift_s[WIDTH-1:0];
        step_x_s = {x_r[WIDTH-2:0], 1'b0};
      end
`else
      step_p_s = p_r;
`endif
    end
    if (op_r == OP_MUL) begin
      iter_res_s = step_p_s;
    end else begin
      iter_res_s = step_x_s;
    end
  end

  // Next-state logic; an accept in DONE re-enters directly
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = iter_s ? ST_BUSY : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_s = iter_s ? ST_BUSY : ST_DONE;
        end else if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered result/status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_ADD;
      p_r      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      cnt_r    <= '0;
      result_r <= '0;
      flags_r  <= 2'b00;
      dz_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r  <= bus.op;
        cnt_r <= '0;
        if (iter_s) begin
          p_r <= '0;
          x_r <= bus.a;
          y_r <= bus.b;
        end else begin
          result_r <= fast_res_s;
          flags_r  <= flags_of(fast_res_s);
          dz_r     <= fast_dz_s;
        end
      end else if (state_r == ST_BUSY) begin
        p_r <= step_p_s;
        x_r <= step_x_s;
        y_r <= step_y_s;
        if (last_s) begin
          cnt_r    <= '0;
          result_r <= iter_res_s;
          flags_r  <= flags_of(iter_res_s);
          dz_r     <= 1'b0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32, FAST_MUL=0); adapts DIVA expectations to ALU_DIV_EN.
module tb_alu_seq;
  localparam int WIDTH = 32;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   busy_n;
  int   rdy_bad;
  int   seen_v;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH), .FAST_MUL(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic wait_done(output int busy, output int bad);
    busy = 0;
    bad  = 0;
    while (bus.out_valid !== 1'b1 && busy < 64) begin
      if (bus.in_ready !== 1'b0) bad++;
      busy++;
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd5, 32'd5);
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_flags", bus.flags, 2'b00);
    chk("rst_dz", bus.dz, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    drive(1'b0, OP_ADD, 32'd0, 32'd0);
    step();
    chk("idle_out_valid", bus.out_valid, 1'b0);

    // add/sub wraparound and flags
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1);
    step();
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_result", bus.result, 32'h0);
    chk("add_flags", bus.flags, 2'b01);
    drive(1'b1, OP_SUB, 32'h0, 32'h1);
    step();
    chk("sub_result", bus.result, 32'hFFFF_FFFF);
    chk("sub_flags", bus.flags, 2'b10);
    chk("sub_dz", bus.dz, 1'b0);
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    step();
    chk("drain_idle", bus.out_valid, 1'b0);

    // back-to-back single-cycle ops
    drive(1'b1, OP_ADD, 32'd3, 32'd4);
    step();
    chk("b2b_add", bus.result, 32'h7);
    chk("b2b_ready", bus.in_ready, 1'b1);
    drive(1'b1, OP_XOR, 32'hF0, 32'hFF);
    step();
    chk("b2b_xor", bus.result, 32'h0F);
    chk("b2b_xor_valid", bus.out_valid, 1'b1);
    drive(1'b1, OP_NOT, 32'h0, 32'h1234);
    step();
    chk("b2b_not", bus.result, 32'hFFFF_FFFF);
    chk("b2b_not_flags", bus.flags, 2'b10);
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    step();

    // iterative multiply; operands changed while busy must not matter
    drive(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0003);
    step();
    drive(1'b0, OP_ADD, 32'h1, 32'h1);
    wait_done(busy_n, rdy_bad);
    chk("mul_busy_cycles", busy_n, 32);
    chk("mul_in_ready_low", rdy_bad, 0);
    chk("mul_result", bus.result, 32'h0003_0000);
    chk("mul_flags", bus.flags, 2'b00);
    chk("mul_dz", bus.dz, 1'b0);
    step();

    // divide and divide-by-zero
    drive(1'b1, OP_DIV, 32'd100, 32'd7);
    step();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    wait_done(busy_n, rdy_bad);
`ifdef ALU_DIV_EN
    chk("div_busy_cycles", busy_n, 32);
    chk("div_result", bus.result, 32'd14);
    chk("div_dz", bus.dz, 1'b0);
    chk("div_flags", bus.flags, 2'b00);
`else
    chk("div_busy_cycles", busy_n, 0);
    chk("div_result", bus.result, 32'd0);
    chk("div_dz", bus.dz, 1'b1);
    chk("div_flags", bus.flags, 2'b01);
`endif
    step();
    drive(1'b1, OP_DIV, 32'd5, 32'd0);
    step();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    chk("dz_valid", bus.out_valid, 1'b1);
`ifdef ALU_DIV_EN
    chk("dz_result", bus.result, 32'hFFFF_FFFF);
    chk("dz_flags", bus.flags, 2'b10);
`else
    chk("dz_result", bus.result, 32'h0);
    chk("dz_flags", bus.flags, 2'b01);
`endif
    chk("dz_dz", bus.dz, 1'b1);
    step();

    // stall in DONE: result held, new request refused
    bus.out_ready = 1'b0;
    drive(1'b1, OP_DIV, 32'd200, 32'd9);
    step();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    wait_done(busy_n, rdy_bad);
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_in_ready", bus.in_ready, 1'b0);
`ifdef ALU_DIV_EN
      chk("stall_result", bus.result, 32'd22);
`else
      chk("stall_result", bus.result, 32'd0);
`endif
    end

    // drain and accept a new iterative op together, then abort it with rst
    bus.out_ready = 1'b1;
`ifdef ALU_DIV_EN
    drive(1'b1, OP_DIV, 32'd1000, 32'd3);
`else
    drive(1'b1, OP_MUL, 32'd1000, 32'd3);
`endif
    step();
    drive(1'b0, OP_ADD, 32'h0, 32'h0);
    chk("abort_busy", bus.in_ready, 1'b0);
    for (int i = 0; i < 9; i++) step();
    chk("abort_pre_valid", bus.out_valid, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_result", bus.result, 32'h0);
    chk("abort_flags", bus.flags, 2'b00);
    chk("abort_dz", bus.dz, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    seen_v = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) seen_v++;
    end
    chk("abort_no_result", seen_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
